// File: rtl/transpose_sched.sv
`default_nettype none
// ============================================================================
//  Module      : transpose_sched
//  Description : Scheduler for a shared transpose/passthrough switch network.
//                Grants one requester per cycle in round-robin order. The
//                network mode only changes once the pipeline has drained.
//                A burst limit keeps either mode from starving the other.
//                An ID FIFO tracks operations in flight so that each network
//                output reports the requester it belongs to.
//                Optional counters are enabled by defining
//                TRANSPOSE_SCHED_PERF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module transpose_sched #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_MG    = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         req_tp,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       sw_ctrl,
    output logic                       sw_in_val,
    input  logic                       sw_out_val,
    output logic                       done,
    output logic [$clog2(NUM_REQ)-1:0] done_id,
    output logic                       busy,
    output logic                       err,
    output logic [31:0]                perf_grants,
    output logic [31:0]                perf_drain
);

    localparam int IDW   = $clog2(NUM_REQ);
    localparam int DEPTH = NUM_MG + 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW    = $clog2(MAX_BURST + 1);

    localparam logic [CW-1:0]  CNT_FULL  = CW'(DEPTH);
    localparam logic [PW-1:0]  PTR_LAST  = PW'(DEPTH - 1);
    localparam logic [BW-1:0]  BURST_MAX = BW'(MAX_BURST);
    localparam logic [IDW-1:0] IDX_LAST  = IDW'(NUM_REQ - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // State and datapath registers
    logic [1:0]     state_q,   state_d;
    logic           mode_q,    mode_d;
    logic [IDW-1:0] rr_ptr_q,  rr_ptr_d;
    logic [BW-1:0]  burst_q,   burst_d;
    logic [PW-1:0]  wr_ptr_q,  wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q,  rd_ptr_d;
    logic [CW-1:0]  count_q,   count_d;
    logic           done_q,    done_d;
    logic [IDW-1:0] done_id_q, done_id_d;
    logic           err_q,     err_d;
    logic [IDW-1:0] id_mem_q [DEPTH];

    // Arbitration and control wires
    logic [NUM_REQ-1:0] mode_mask;
    logic [NUM_REQ-1:0] same_vec;
    logic [NUM_REQ-1:0] opp_vec;
    logic               any_found;
    logic [IDW-1:0]     any_idx;
    logic               same_found;
    logic [IDW-1:0]     same_idx;
    logic               fifo_full;
    logic               fifo_empty;
    logic               grant_en;
    logic [IDW-1:0]     grant_idx;
    logic               toggle;
    logic               opp_pending;
    logic               push;
    logic               pop;

    // First set bit of vec at or after ptr, wrapping; MSB of result = found
    function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] vec,
                                             input logic [IDW-1:0]     ptr);
        logic           found;
        logic [IDW-1:0] idx;
        logic [IDW:0]   pos;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, ptr} + (IDW+1)'(k);
            if (pos >= (IDW+1)'(NUM_REQ)) begin
                pos = pos - (IDW+1)'(NUM_REQ);
            end
            if (!found && vec[pos[IDW-1:0]]) begin
                found = 1'b1;
                idx   = pos[IDW-1:0];
            end
        end
        return {found, idx};
    endfunction

    // Split requests by mode and pick round-robin winners
    always_comb begin
        mode_mask              = {NUM_REQ{mode_q}};
        same_vec               = req & ~(req_tp ^ mode_mask);
        opp_vec                = req & (req_tp ^ mode_mask);
        {any_found, any_idx}   = rr_pick(req, rr_ptr_q);
        {same_found, same_idx} = rr_pick(same_vec, rr_ptr_q);
        fifo_full              = (count_q == CNT_FULL);
        fifo_empty             = (count_q == '0);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, grant decision and mode update
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        toggle    = 1'b0;
        grant_en  = 1'b0;
        grant_idx = '0;
        case (state_q)
            ST_IDLE: begin
                // Pipeline is empty here, so the mode may follow the winner
                if (any_found) begin
                    state_d   = ST_RUN;
                    mode_d    = req_tp[any_idx];
                    grant_en  = !fifo_full;
                    grant_idx = any_idx;
                end
            end
            ST_RUN: begin
                if ((req == '0) && fifo_empty) begin
                    state_d = ST_IDLE;
                end else if ((same_vec == '0) && (opp_vec != '0)) begin
                    state_d = ST_DRAIN;
                end else if ((burst_q == BURST_MAX) && (opp_vec != '0)) begin
                    state_d = ST_DRAIN;
                end else if (same_found && !fifo_full) begin
                    grant_en  = 1'b1;
                    grant_idx = same_idx;
                end
            end
            ST_DRAIN: begin
                // Flip only once every in-flight operation has completed
                if (fifo_empty) begin
                    state_d = ST_RUN;
                    mode_d  = ~mode_q;
                    toggle  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: grant vector, network controls and busy
    always_comb begin
        gnt = '0;
        if (!rst && grant_en) begin
            gnt[grant_idx] = 1'b1;
        end
        sw_in_val = |gnt;
        // In IDLE the winner's mode is presented with its own grant
        if (rst) begin
            sw_ctrl = 1'b0;
        end else if (state_q == ST_IDLE) begin
            sw_ctrl = mode_d;
        end else begin
            sw_ctrl = mode_q;
        end
        busy = (count_q != '0) || (state_q != ST_IDLE);
    end

    // Burst counter and round-robin pointer
    always_comb begin
        opp_pending = |(req & (req_tp ^ {NUM_REQ{mode_d}}));
        if (toggle || !opp_pending) begin
            burst_d = '0;
        end else if (grant_en && (burst_q < BURST_MAX)) begin
            burst_d = burst_q + BW'(1);
        end else begin
            burst_d = burst_q;
        end
        rr_ptr_d = rr_ptr_q;
        if (grant_en) begin
            rr_ptr_d = (grant_idx == IDX_LAST) ? '0 : grant_idx + IDW'(1);
        end
    end

    // ID FIFO bookkeeping, completion pulse and sticky error
    always_comb begin
        push     = grant_en;
        pop      = sw_out_val && !fifo_empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        done_d    = pop;
        done_id_d = pop ? id_mem_q[rd_ptr_q] : '0;
        err_d     = err_q || (sw_out_val && fifo_empty);
    end

    // Control and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= 1'b0;
            rr_ptr_q  <= '0;
            burst_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            err_q     <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            rr_ptr_q  <= rr_ptr_d;
            burst_q   <= burst_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            err_q     <= err_d;
        end
    end

    // ID storage; contents are meaningless once the pointers are cleared
    always_ff @(posedge clk) begin
        if (push) begin
            id_mem_q[wr_ptr_q] <= grant_idx;
        end
    end

    assign done    = done_q;
    assign done_id = done_id_q;
    assign err     = err_q;

`ifdef TRANSPOSE_SCHED_PERF_EN
    logic [31:0] perf_grants_q, perf_grants_d;
    logic [31:0] perf_drain_q,  perf_drain_d;

    // Wrapping grant and drain-cycle counters
    always_comb begin
        perf_grants_d = perf_grants_q + (grant_en ? 32'd1 : 32'd0);
        perf_drain_d  = perf_drain_q + ((state_q == ST_DRAIN) ? 32'd1 : 32'd0);
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grants_q <= '0;
            perf_drain_q  <= '0;
        end else begin
            perf_grants_q <= perf_grants_d;
            perf_drain_q  <= perf_drain_d;
        end
    end

    assign perf_grants = perf_grants_q;
    assign perf_drain  = perf_drain_q;
`else
    assign perf_grants = '0;
    assign perf_drain  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_transpose_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_transpose_sched
//  Description : Directed and random stimulus for transpose_sched, compared
//                cycle by cycle against a queue-based behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_transpose_sched;

    localparam int NR  = 4;
    localparam int NMG = 8;
    localparam int MB  = 4;

    logic          clk;
    logic          rst;
    logic [NR-1:0] req;
    logic [NR-1:0] req_tp;
    logic [NR-1:0] gnt;
    logic          sw_ctrl;
    logic          sw_in_val;
    logic          sw_out_val;
    logic          done;
    logic [1:0]    done_id;
    logic          busy;
    logic          err;
    logic [31:0]   perf_grants;
    logic [31:0]   perf_drain;

    transpose_sched #(
        .NUM_REQ   (NR),
        .NUM_MG    (NMG),
        .MAX_BURST (MB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_tp      (req_tp),
        .gnt         (gnt),
        .sw_ctrl     (sw_ctrl),
        .sw_in_val   (sw_in_val),
        .sw_out_val  (sw_out_val),
        .done        (done),
        .done_id     (done_id),
        .busy        (busy),
        .err         (err),
        .perf_grants (perf_grants),
        .perf_drain  (perf_drain)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_pass;
    int n_fail;

    // Reference model state
    int  m_phase;     // 0 idle, 1 granting, 2 waiting for pipeline to empty
    bit  m_mode;
    int  m_ptr;
    int  m_burst;
    int  m_fifo[$];
    bit  m_done;
    int  m_done_id;
    bit  m_err;
    int  m_grants;
    int  m_drains;

    // Network model and observation
    bit            net_manual;
    logic [NMG-1:0] pipe;
    bit            last_exp_grant;
    int            cyc;
    logic [NR-1:0] obs_gnt;
    logic          obs_done;
    logic [1:0]    obs_done_id;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        assert (act === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic bit bit_of(input logic [NR-1:0] v, input int i);
        logic [NR-1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    function automatic int pick(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++) begin
            if (bit_of(v, (p + k) % NR)) return (p + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_mode = 0; m_ptr = 0; m_burst = 0;
        m_fifo.delete();
        m_done = 0; m_done_id = 0; m_err = 0;
        m_grants = 0; m_drains = 0;
    endtask

    // Predict this cycle's outputs, compare, then advance the model
    task automatic model_step();
        logic [NR-1:0] same;
        logic [NR-1:0] opp;
        logic [NR-1:0] exp_gnt;
        int  sz, w, gidx, nphase;
        bit  nmode, tog, full, opp2;
        sz = m_fifo.size();
        full = (sz == NMG + 1);
        same = '0;
        opp  = '0;
        for (int i = 0; i < NR; i++) begin
            if (bit_of(req, i)) begin
                if (bit_of(req_tp, i) == m_mode) same[i] = 1'b1;
                else opp[i] = 1'b1;
            end
        end
        gidx = -1; nphase = m_phase; nmode = m_mode; tog = 0;
        case (m_phase)
            0: begin
                w = pick(req, m_ptr);
                if (w >= 0) begin
                    nmode  = bit_of(req_tp, w);
                    nphase = 1;
                    if (!full) gidx = w;
                end
            end
            1: begin
                if (req == '0 && sz == 0) nphase = 0;
                else if (same == '0 && opp != '0) nphase = 2;
                else if (m_burst >= MB && opp != '0) nphase = 2;
                else begin
                    w = pick(same, m_ptr);
                    if (w >= 0 && !full) gidx = w;
                end
            end
            default: begin
                if (sz == 0) begin
                    nmode = !m_mode; tog = 1; nphase = 1;
                end
            end
        endcase
        exp_gnt = '0;
        if (gidx >= 0) exp_gnt = NR'(1) << gidx;

        chk("gnt",       32'(gnt),       32'(exp_gnt));
        chk("sw_in_val", 32'(sw_in_val), 32'(gidx >= 0));
        chk("sw_ctrl",   32'(sw_ctrl),   32'((m_phase == 0) ? nmode : m_mode));
        chk("done",      32'(done),      32'(m_done));
        chk("done_id",   32'(done_id),   32'(m_done_id));
        chk("err",       32'(err),       32'(m_err));
        chk("busy",      32'(busy),      32'((sz != 0) || (m_phase != 0)));
`ifdef TRANSPOSE_SCHED_PERF_EN
        chk("perf_grants", perf_grants, 32'(m_grants));
        chk("perf_drain",  perf_drain,  32'(m_drains));
`else
        chk("perf_grants", perf_grants, 32'd0);
        chk("perf_drain",  perf_drain,  32'd0);
`endif

        opp2 = 0;
        for (int i = 0; i < NR; i++) begin
            if (bit_of(req, i) && (bit_of(req_tp, i) != nmode)) opp2 = 1;
        end
        if (tog || !opp2) m_burst = 0;
        else if (gidx >= 0 && m_burst < MB) m_burst++;
        if (gidx >= 0) begin
            m_ptr = (gidx + 1) % NR;
            m_grants++;
        end
        if (m_phase == 2) m_drains++;
        m_done = 0; m_done_id = 0;
        if (sw_out_val) begin
            if (sz > 0) begin
                m_done_id = m_fifo.pop_front();
                m_done = 1;
            end else begin
                m_err = 1;
            end
        end
        if (gidx >= 0) m_fifo.push_back(gidx);
        m_phase = nphase;
        m_mode  = nmode;
        last_exp_grant = (gidx >= 0);
    endtask

    // One clock: inputs at posedge+1, checks on the falling edge
    task automatic tick(input logic [NR-1:0] r, input logic [NR-1:0] t, input logic msow);
        req    = r;
        req_tp = t;
        sw_out_val = net_manual ? msow : pipe[NMG-1];
        @(negedge clk);
        obs_gnt     = gnt;
        obs_done    = done;
        obs_done_id = done_id;
        model_step();
        pipe = {pipe[NMG-2:0], last_exp_grant};
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b1; req = '1; req_tp = '1; sw_out_val = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            chk("rst_gnt",       32'(gnt),       32'd0);
            chk("rst_sw_in_val", 32'(sw_in_val), 32'd0);
            chk("rst_sw_ctrl",   32'(sw_ctrl),   32'd0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        model_reset();
        pipe = '0;
    endtask

    // Idle the requesters until nothing is in flight (bounded)
    task automatic settle();
        int k;
        k = 0;
        while (!(m_phase == 0 && m_fifo.size() == 0) && k < 80) begin
            tick('0, '0, net_manual && (m_fifo.size() > 0));
            k++;
        end
        chk("settle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int first_g, first_d, gcount, g1;
        logic [1:0] first_id;
        n_checks = 0; n_pass = 0; n_fail = 0;
        cyc = 0; net_manual = 0; pipe = '0;
        rst = 1'b1; req = '0; req_tp = '0; sw_out_val = 1'b0;
        model_reset();
        do_reset(2);

        // Single transpose requester streaming through the network
        first_g = -1; first_d = -1; first_id = '1;
        for (int k = 0; k < 20; k++) begin
            tick(4'b0001, 4'b0001, 1'b0);
            if (obs_gnt != '0 && first_g < 0) first_g = cyc;
            if (obs_done && first_d < 0) begin
                first_d  = cyc;
                first_id = obs_done_id;
            end
        end
        chk("r033_latency", 32'(first_d - first_g), 32'd9);
        chk("r033_done_id", 32'(first_id), 32'd0);
        settle();

        // Two passthrough requesters alternate
        for (int k = 0; k < 10; k++) tick(4'b0011, 4'b0000, 1'b0);
        settle();

        // Passthrough stream, then only a transpose request remains
        for (int k = 0; k < 5; k++) tick(4'b0001, 4'b0000, 1'b0);
        for (int k = 0; k < 20; k++) tick(4'b0010, 4'b0010, 1'b0);
        settle();

        // Burst limit: both modes held, neither may starve
        g1 = 0;
        for (int k = 0; k < 40; k++) begin
            tick(4'b0011, 4'b0001, 1'b0);
            if (obs_gnt[1]) g1++;
        end
        chk("r036_no_starve", 32'(g1 != 0), 32'd1);
        settle();

        // Stalled network: FIFO fills, then one completion frees one slot
        net_manual = 1;
        gcount = 0;
        for (int k = 0; k < 12; k++) begin
            tick(4'b0001, 4'b0000, 1'b0);
            if (obs_gnt != '0) gcount++;
        end
        chk("r037_full_hold", 32'(gcount), 32'd9);
        gcount = 0;
        tick(4'b0001, 4'b0000, 1'b1);
        if (obs_gnt != '0) gcount++;
        for (int k = 0; k < 3; k++) begin
            tick(4'b0001, 4'b0000, 1'b0);
            if (obs_gnt != '0) gcount++;
        end
        chk("r037_one_more", 32'(gcount), 32'd1);
        settle();

        // Random requests with a fixed-latency network
        net_manual = 0;
        pipe = '0;
        for (int k = 0; k < 300; k++) tick(NR'($urandom), NR'($urandom), 1'b0);
        settle();

        // Random requests with random completion timing
        net_manual = 1;
        for (int k = 0; k < 400; k++) begin
            tick(NR'($urandom), NR'($urandom),
                 ($urandom_range(0, 2) == 0) && (m_fifo.size() > 0));
        end
        settle();

        // Reset with operations in flight, then a stray network output
        net_manual = 0;
        pipe = '0;
        for (int k = 0; k < 3; k++) tick(4'b0001, 4'b0000, 1'b0);
        do_reset(2);
        chk("r038_perf_grants_zero", perf_grants, 32'd0);
        net_manual = 1;
        tick('0, '0, 1'b1);
        tick('0, '0, 1'b0);
        chk("r038_err", 32'(err), 32'd1);
        chk("r038_no_done", 32'(done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/transpose_sched.md
TRANSPOSE_SCHED -- requirements
Module: transpose_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the switch network.
REQ-002 Parameter NUM_MG, default 8, switch network pipeline depth in cycles, from sw_in_val to sw_out_val.
REQ-003 Parameter MAX_BURST, default 16, maximum consecutive same-mode grants while an opposite-mode request waits.
REQ-004 Port clk, input, 1, clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1, reset; synchronous, active-high.
REQ-006 Port req, input, NUM_REQ, per-requester request valid.
REQ-007 Port req_tp, input, NUM_REQ, per-requester mode: 1 = transpose, 0 = passthrough.
REQ-008 Port gnt, output, NUM_REQ, one-hot grant; a request is accepted in any cycle where req[i] and gnt[i] are both high.
REQ-009 Port sw_ctrl, output, 1, network mode select; driven from the mode register.
REQ-010 Port sw_in_val, output, 1, network input valid; equals OR of gnt.
REQ-011 Port sw_out_val, input, 1, network output valid.
REQ-012 Port done, output, 1, registered completion pulse.
REQ-013 Port done_id, output, clog2(NUM_REQ), requester index of the completing operation.
REQ-014 Port busy, output, 1, high when the in-flight count is nonzero or state is not IDLE.
REQ-015 Port err, output, 1, sticky error; set on sw_out_val while the ID FIFO is empty.

Function
REQ-016 State machine SHALL have three states: IDLE, RUN, DRAIN.
REQ-017 IDLE -> RUN when any req is high.
  - Mode register loads req_tp of the round-robin winner among all requesters.
  - The grant SHALL occur in that same cycle.
REQ-018 RUN: grant at most one requester per cycle.
  - Round-robin among requesters with req high and req_tp == mode.
  - Search starts at rr_ptr; rr_ptr advances to the winner+1 (mod NUM_REQ) on each grant.
REQ-019 gnt SHALL be combinational from req, req_tp and registered state, with no added latency.
  - Back-to-back grants on consecutive cycles SHALL be supported.
REQ-020 Mode SHALL never change while the in-flight count is nonzero.
  - sw_ctrl SHALL be stable for every operation in flight.
REQ-021 RUN -> DRAIN, with no grant issued that cycle, when either:
  - only opposite-mode requests are pending; or
  - the burst counter reaches MAX_BURST while an opposite-mode request is pending.
REQ-022 DRAIN: no grants issued.
  - When the in-flight count reaches 0, toggle mode, clear the burst counter, and enter RUN.
REQ-023 RUN -> IDLE when no req is high and the in-flight count is 0.
REQ-024 Burst counter behaviour:
  - Increments on each grant, saturating at MAX_BURST.
  - Clears on mode toggle.
  - Clears in any cycle with no opposite-mode request pending.
REQ-025 ID FIFO, depth NUM_MG+1:
  - Pushes the winner index on each grant.
  - Pops on sw_out_val.
  - Simultaneous push and pop leaves the count unchanged.
REQ-026 When the in-flight count equals NUM_MG+1, gnt SHALL be held at 0.
REQ-027 done SHALL pulse exactly one cycle after each sw_out_val that hits a nonempty FIFO.
  - done_id SHALL be the popped index.
  - done and done_id SHALL be 0 otherwise.
REQ-028 sw_out_val while the FIFO is empty:
  - Set err.
  - Leave the FIFO and count unchanged.
  - Do not pulse done.

Reset
REQ-029 On rst:
  - State IDLE; mode 0; rr_ptr 0; burst counter 0.
  - FIFO and in-flight count cleared.
  - done, done_id and err cleared.
REQ-030 While rst is high, gnt, sw_in_val and sw_ctrl SHALL be 0.
  - Reset mid-operation SHALL discard in-flight IDs.
  - sw_out_val arriving after reset with an empty FIFO SHALL set err.

Configuration
REQ-031 Macro TRANSPOSE_SCHED_PERF_EN adds two outputs:
  - perf_grants, 32 bits, total grants, wrapping.
  - perf_drain, 32 bits, cycles spent in DRAIN, wrapping.
  - Both SHALL clear on rst.
REQ-032 Without TRANSPOSE_SCHED_PERF_EN, both ports SHALL exist and be tied to 0, with no counter logic.

Verification
REQ-033 req=0001, req_tp=0001 held, network model NUM_MG=8 -> gnt[0] every cycle; sw_ctrl=1; first done 9 cycles after first grant, done_id=0.
REQ-034 req=0011, req_tp=0000 -> grants alternate 0,1,0,1; sw_ctrl=0 throughout.
REQ-035 req0 passthrough active, req1 transpose raised -> DRAIN; no grants until the in-flight count is 0; mode flips to 1; next grant goes to requester 1.
REQ-036 MAX_BURST=4, req0 transpose held, req1 passthrough held -> 4 grants to 0, then DRAIN, then grants to 1; no starvation.
REQ-037 Network output stalled, 9 grants issued -> gnt held at 0; one sw_out_val -> exactly one more grant allowed.
REQ-038 rst with 3 operations in flight, then sw_out_val -> err=1, done=0; with TRANSPOSE_SCHED_PERF_EN, perf_grants=0 after rst.
